seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter W, default 64, operand and result width in bits (W >= 8, even).
REQ-002 clk  input  1  single clock, all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 a, b  input  W  operands.
REQ-007 op  input  4  operation select.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 result  output  W  operation result.
REQ-011 flags  output  5  {dz, v, c, n, z}.

Function
REQ-012 Op codes SHALL be:
- 0000 ADD; 0001 SUB; 0010 MUL, low W bits; 0011 DIV, unsigned quotient.
- 0100 SHL by 1; 0101 SHR by 1; 0110 ROL by 1 over full W; 0111 ROR by 1 over full W.
- 1000 AND; 1001 OR; 1010 XOR; 1011 NOR; 1100 NAND; 1101 XNOR.
- 1110 GT, unsigned, result 1/0; 1111 EQ, result 1/0.
REQ-013 States SHALL be IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 A request SHALL be accepted on an edge with in_valid & in_ready; a, b and op SHALL be captured at that edge.
REQ-015 Non-MUL/DIV ops SHALL go IDLE->DONE on accept, with out_valid high from the next cycle (latency 1).
REQ-016 MUL and DIV SHALL go IDLE->BUSY and iterate one bit per cycle, W cycles, then BUSY->DONE, giving out_valid W+1 cycles after accept.
- MUL SHALL be shift-add.
- DIV SHALL be restoring.
REQ-017 In DONE, result and flags SHALL be held stable until out_valid & out_ready; the block SHALL then return to IDLE on that edge.
REQ-018 in_valid during BUSY or DONE SHALL be ignored, with no capture.
REQ-019 z SHALL be 1 when result == 0 and n SHALL equal result[W-1], for all ops.
REQ-020 c SHALL be set as follows and be 0 for all other ops:
- ADD: carry-out.
- SUB: borrow (a < b unsigned).
- MUL: upper W bits of the 2W product non-zero.
- SHL: a[W-1]; SHR: a[0].
REQ-021 v SHALL be signed two's-complement overflow for ADD/SUB and 0 for all other ops.
REQ-022 DIV with b == 0 SHALL complete in 1 cycle with result all-ones and dz=1; dz SHALL be 0 otherwise.
REQ-023 Arithmetic SHALL be modulo 2^W; no internal value SHALL be truncated below W bits before flag computation.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, in_ready=1 after release, out_valid=0, result=0, flags=0, and clear iteration counters.
REQ-025 Reset during BUSY or DONE SHALL abandon the operation with no result delivered.

Structure
REQ-026 Package alu_pkg SHALL hold the op-code constants, the state enum and flag bit indices.
REQ-027 MUL/DIV iteration SHALL live in sub-module iter_muldiv, which has start, mode, a, b, busy, done and a 2W product/quotient output.

Verification
REQ-028 W=8, ADD a=0xFF b=0x01 -> result 0x00, z=1, c=1, v=0, out_valid 1 cycle after accept.
REQ-029 W=8, SUB a=0x80 b=0x01 -> result 0x7F, v=1, c=0, n=0.
REQ-030 W=8, MUL a=0x10 b=0x11 -> result 0x10, c=1, out_valid exactly 9 cycles after accept.
REQ-031 W=8, DIV a=0x64 b=0x07 -> 0x0E; DIV b=0 -> 0xFF with dz=1 after 1 cycle.
REQ-032 W=64, ROL a=0x8000_0000_0000_0001 -> 0x0000_0000_0000_0003; out_ready held low 5 cycles -> result stable and in_ready=0 throughout.
REQ-033 Assert rst_n low mid-MUL at cycle 4 -> out_valid stays 0; after release a new ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Op codes, FSM state encoding and flag bit positions shared by seq_alu and its bench.
package alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_SHL  = 4'b0100;
  localparam logic [3:0] OP_SHR  = 4'b0101;
  localparam logic [3:0] OP_ROL  = 4'b0110;
  localparam logic [3:0] OP_ROR  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1011;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_XNOR = 4'b1101;
  localparam logic [3:0] OP_GT   = 4'b1110;
  localparam logic [3:0] OP_EQ   = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int FLG_Z  = 0;
  localparam int FLG_N  = 1;
  localparam int FLG_C  = 2;
  localparam int FLG_V  = 3;
  localparam int FLG_DZ = 4;

  // Divide-by-zero bypasses the iterator and completes like a single-cycle op.
  function automatic logic needs_iter(input logic [3:0] op, input logic b_nonzero);
    return (op == OP_MUL) || ((op == OP_DIV) && b_nonzero);
  endfunction
endpackage

// File: rtl/iter_muldiv.sv
// Bit-serial unsigned multiplier (shift-add) and divider (restoring), one bit per clock.
// res holds {high, low} of the product, or {remainder, quotient} for division.
module iter_muldiv
  import alu_pkg::*;
#(
  parameter int W = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] res
);
  localparam int CW = $clog2(W);

  logic          r_busy;
  logic          r_done;
  logic          r_mode;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_hi;
  logic [W-1:0]  r_lo;

  logic          w_mode;
  logic [W-1:0]  w_b;
  logic [W-1:0]  w_hi;
  logic [W-1:0]  w_lo;
  logic [W-1:0]  w_hi_nxt;
  logic [W-1:0]  w_lo_nxt;
  logic [W:0]    w_sum;
  logic [W:0]    w_rem_sh;
  logic [W-1:0]  w_diff;

  // The start cycle already performs step 1 on the raw operands, so the last step lands W-1 cycles later.
  always_comb begin
    w_mode   = start ? mode : r_mode;
    w_b      = start ? b : r_b;
    w_hi     = start ? {W{1'b0}} : r_hi;
    w_lo     = start ? a : r_lo;
    w_sum    = {1'b0, w_hi} + (w_lo[0] ? {1'b0, w_b} : {(W+1){1'b0}});
    w_rem_sh = {w_hi, w_lo[W-1]};
    w_diff   = w_rem_sh[W-1:0] - w_b;
    if (w_mode) begin
      if (w_rem_sh >= {1'b0, w_b}) begin
        w_hi_nxt = w_diff;
        w_lo_nxt = {w_lo[W-2:0], 1'b1};
      end else begin
        w_hi_nxt = w_rem_sh[W-1:0];
        w_lo_nxt = {w_lo[W-2:0], 1'b0};
      end
    end else begin
      w_hi_nxt = w_sum[W:1];
      w_lo_nxt = {w_sum[0], w_lo[W-1:1]};
    end
  end

  // Step counter and datapath registers; done pulses for one cycle after the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_mode <= 1'b0;
      r_cnt  <= {CW{1'b0}};
      r_b    <= {W{1'b0}};
      r_hi   <= {W{1'b0}};
      r_lo   <= {W{1'b0}};
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_mode <= mode;
        r_b    <= b;
        r_hi   <= w_hi_nxt;
        r_lo   <= w_lo_nxt;
        r_cnt  <= CW'(W - 1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_hi  <= w_hi_nxt;
        r_lo  <= w_lo_nxt;
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign res  = {r_hi, r_lo};
endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes: single-cycle ops finish on accept,
// MUL/DIV iterate in iter_muldiv; result and flags are held until consumed.
module seq_alu
  import alu_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [4:0]   flags
);
  state_t         r_state;
  logic           r_in_ready;
  logic           r_out_valid;
  logic [W-1:0]   r_result;
  logic [4:0]     r_flags;
  logic [3:0]     r_op;

  logic [W:0]     w_add;
  logic [W:0]     w_sub;
  logic [W-1:0]   w_res;
  logic           w_c;
  logic           w_v;
  logic           w_dz;
  logic           w_start;
  logic           w_md_busy;
  logic           w_md_done;
  logic [2*W-1:0] w_md_res;

  function automatic logic [4:0] pack_flags(input logic [W-1:0] res, input logic c,
                                            input logic v, input logic dz);
    logic [4:0] f;
    f         = 5'b00000;
    f[FLG_Z]  = (res == {W{1'b0}});
    f[FLG_N]  = res[W-1];
    f[FLG_C]  = c;
    f[FLG_V]  = v;
    f[FLG_DZ] = dz;
    return f;
  endfunction

  assign w_start = in_valid & r_in_ready & needs_iter(op, |b);

  iter_muldiv #(.W(W)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_start),
    .mode  (op == OP_DIV),
    .a     (a),
    .b     (b),
    .busy  (w_md_busy),
    .done  (w_md_done),
    .res   (w_md_res)
  );

  // Single-cycle datapath; the add/sub are one bit wider so carry and borrow survive.
  always_comb begin
    w_res = {W{1'b0}};
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_dz  = 1'b0;
    w_add = {1'b0, a} + {1'b0, b};
    w_sub = {1'b0, a} - {1'b0, b};
    case (op)
      OP_ADD: begin
        w_res = w_add[W-1:0];
        w_c   = w_add[W];
        w_v   = (a[W-1] == b[W-1]) && (w_add[W-1] != a[W-1]);
      end
      OP_SUB: begin
        w_res = w_sub[W-1:0];
        w_c   = w_sub[W];
        w_v   = (a[W-1] != b[W-1]) && (w_sub[W-1] != a[W-1]);
      end
      OP_DIV: begin
        if (b == {W{1'b0}}) begin
          w_res = {W{1'b1}};
          w_dz  = 1'b1;
        end else begin
          w_res = {W{1'b0}};
        end
      end
      OP_SHL: begin
        w_res = {a[W-2:0], 1'b0};
        w_c   = a[W-1];
      end
      OP_SHR: begin
        w_res = {1'b0, a[W-1:1]};
        w_c   = a[0];
      end
      OP_ROL:  w_res = {a[W-2:0], a[W-1]};
      OP_ROR:  w_res = {a[0], a[W-1:1]};
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_NOR:  w_res = ~(a | b);
      OP_NAND: w_res = ~(a & b);
      OP_XNOR: w_res = ~(a ^ b);
      OP_GT:   w_res = {{(W-1){1'b0}}, (a > b)};
      OP_EQ:   w_res = {{(W-1){1'b0}}, (a == b)};
      default: w_res = {W{1'b0}};
    endcase
  end

  // Control FSM with registered handshake outputs and result/flag holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= {W{1'b0}};
      r_flags     <= 5'b00000;
      r_op        <= OP_ADD;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op       <= op;
            r_in_ready <= 1'b0;
            if (w_start) begin
              r_state <= ST_BUSY;
            end else begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_res;
              r_flags     <= pack_flags(w_res, w_c, w_v, w_dz);
            end
          end
        end
        ST_BUSY: begin
          if (w_md_done) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_md_res[W-1:0];
            r_flags     <= pack_flags(w_md_res[W-1:0],
                                      (r_op == OP_MUL) && (w_md_res[2*W-1:W] != {W{1'b0}}),
                                      1'b0, 1'b0);
          end else if (!w_md_busy) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;
endmodule
